multiplier_datapath: RTL and testbench
======================================

// Module: multiplier_datapath
// PURPOSE
//   Register/arithmetic datapath of the 8-bit signed shift-add multiplier. Sits directly
//   downstream of the multiplier control FSM: consumes LD_XA/LD_B/Shift_EN/Cnt_EN/Clr_XA/
//   SUB_ADD and returns M (multiplier LSB) and count[2:0] to it. Holds X (sign ext), A (high
//   product byte) and B (multiplier, then low product byte); 9-bit add/sub against switches S.
// PARAMETERS
//   WIDTH  8  operand width; A, B, S are WIDTH bits, adder is WIDTH+1, count is $clog2(WIDTH)
// PORTS
//   Clk       in   1      system clock, all state updates on posedge
//   Reset     in   1      synchronous, active-high; clears all state
//   S         in   WIDTH  multiplicand (signed), also B load value
//   LD_XA     in   1      load {X,A} <= adder result
//   LD_B      in   1      load B <= S
//   Shift_EN  in   1      arithmetic right shift of {X,A,B}
//   Cnt_EN    in   1      increment count
//   Clr_XA    in   1      clear X, A and count
//   SUB_ADD   in   1      0: A+S, 1: A-S
//   M         out  1      = B[0], combinational from register
//   count     out  3      shift counter
//   X         out  1      sign-extension bit
//   Aval      out  WIDTH  register A
//   Bval      out  WIDTH  register B
// BEHAVIOUR
//   - One clock (Clk); reset synchronous active-high. Reset: X=0, A=0, B=0, count=0, so M=0.
//     Reset dominates every control input in the same cycle; reset mid-multiply aborts cleanly.
//   - Adder (combinational): sum[8:0] = {A[7],A} + ({S[7],S} ^ {9{SUB_ADD}}) + SUB_ADD.
//     9-bit two's complement, never overflows for 8-bit signed operands.
//   - X/A update priority per cycle: Reset > Clr_XA (X=0,A=0) > LD_XA (X=sum[8],A=sum[7:0])
//     > Shift_EN (X=X, A={X,A[7:1]}) > hold.
//   - B update priority: Reset > LD_B (B=S) > Shift_EN (B={A[0],B[7:1]}, pre-update A) > hold.
//   - Clr_XA and LD_B together (clear/load state): both take effect same edge.
//   - LD_XA and Shift_EN together (not issued by control): LD_XA wins for X/A; B still shifts
//     using pre-update A[0]. Defined so the bench can check, not relied upon.
//   - count priority: Reset > Clr_XA (0) > Cnt_EN (count+1, 7 wraps to 0) > hold.
//     Cnt_EN independent of Shift_EN.
//   - All register updates are 1-cycle latency; M, X, Aval, Bval, count reflect registers
//     the cycle after the enabling edge. No combinational path from control inputs to outputs.
//   - After 8 shifts with add on M=1 and subtract on the 8th M=1, {A,B} = 16-bit signed
//     product S*B_initial and X = product sign.
// TESTING
//   1. Reset with random prior state -> X=0,A=00,B=00,count=0,M=0 next cycle.
//   2. S=07, Clr_XA=1+LD_B=1 one cycle -> B=07,A=00,X=0,count=0,M=1.
//   3. A=00,S=C5,LD_XA,SUB_ADD=0 -> X=1,A=C5; then LD_XA,SUB_ADD=1,S=C5 -> X=0,A=00.
//   4. X=1,A=81,B=02,Shift_EN -> X=1,A=C0,B=81,M=1; LD_XA+Shift_EN together -> A=sum, B shifted.
//   5. Full FSM-style sequence, B=07 loaded, S=FD(-3) -> X=1,A=FF,B=EB (-21);
//      repeat S=80,B=80 -> A=40,B=00.
//   6. 8 Cnt_EN pulses from 0 -> count 1..7 then 0; Reset asserted at count=5 during a shift
//      -> all registers 0 next cycle, shift suppressed.

Source files
------------

// File: rtl/multiplier_datapath.sv
// Register/arithmetic datapath of the signed shift-add multiplier: holds X, A, B and the
// shift counter, and computes the 9-bit add/subtract of A against the multiplicand S.
module multiplier_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [WIDTH-1:0]         S,
    input  logic                     LD_XA,
    input  logic                     LD_B,
    input  logic                     Shift_EN,
    input  logic                     Cnt_EN,
    input  logic                     Clr_XA,
    input  logic                     SUB_ADD,
    output logic                     M,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     X,
    output logic [WIDTH-1:0]         Aval,
    output logic [WIDTH-1:0]         Bval
);

    localparam int CW = $clog2(WIDTH);

    logic             x_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH:0]   operand;
    logic [WIDTH:0]   sum;

    // Sign-extended operands; subtraction is invert-and-carry-in, so no overflow at 9 bits.
    always_comb begin
        operand = {S[WIDTH-1], S} ^ {(WIDTH+1){SUB_ADD}};
        sum     = {a_reg[WIDTH-1], a_reg} + operand + {{WIDTH{1'b0}}, SUB_ADD};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_reg   <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            cnt_reg <= '0;
        end else begin
            if (Clr_XA) begin
                x_reg <= 1'b0;
                a_reg <= '0;
            end else if (LD_XA) begin
                x_reg <= sum[WIDTH];
                a_reg <= sum[WIDTH-1:0];
            end else if (Shift_EN) begin
                a_reg <= {x_reg, a_reg[WIDTH-1:1]};
            end

            // B shifts in the pre-update A[0] even when LD_XA overrides the A shift.
            if (LD_B) begin
                b_reg <= S;
            end else if (Shift_EN) begin
                b_reg <= {a_reg[0], b_reg[WIDTH-1:1]};
            end

            if (Clr_XA) begin
                cnt_reg <= '0;
            end else if (Cnt_EN) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign M     = b_reg[0];
    assign X     = x_reg;
    assign Aval  = a_reg;
    assign Bval  = b_reg;
    assign count = cnt_reg;

endmodule

// File: tb/tb_multiplier_datapath.sv
// Self-checking bench for multiplier_datapath: a reference model pushes the expected
// {X,A,B,count,M} per driven cycle into a queue, popped and compared after each edge.
module tb_multiplier_datapath;

    logic       Clk;
    logic       Reset;
    logic [7:0] S;
    logic       LD_XA;
    logic       LD_B;
    logic       Shift_EN;
    logic       Cnt_EN;
    logic       Clr_XA;
    logic       SUB_ADD;
    logic       M;
    logic [2:0] count;
    logic       X;
    logic [7:0] Aval;
    logic [7:0] Bval;

    int checks = 0;
    int errors = 0;

    logic [20:0] exp_q[$];
    logic        mx;
    logic [7:0]  ma;
    logic [7:0]  mb;
    logic [2:0]  mc;

    multiplier_datapath #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .S(S), .LD_XA(LD_XA), .LD_B(LD_B),
        .Shift_EN(Shift_EN), .Cnt_EN(Cnt_EN), .Clr_XA(Clr_XA), .SUB_ADD(SUB_ADD),
        .M(M), .count(count), .X(X), .Aval(Aval), .Bval(Bval)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive one cycle of controls, advance the model, push its expectation, step past the edge.
    task automatic drive(input logic rst, input logic clr, input logic ldxa, input logic ldb,
                         input logic sh, input logic cnt, input logic sub, input logic [7:0] s);
        int         a;
        int         sv;
        int         r;
        logic [8:0] r9;
        logic       nx;
        logic [7:0] na;
        logic [7:0] nb;
        logic [2:0] nc;
        Reset = rst; Clr_XA = clr; LD_XA = ldxa; LD_B = ldb;
        Shift_EN = sh; Cnt_EN = cnt; SUB_ADD = sub; S = s;
        a  = $signed(ma);
        sv = $signed(s);
        r  = sub ? (a - sv) : (a + sv);
        r9 = r[8:0];
        nx = mx; na = ma; nb = mb; nc = mc;
        if (rst) begin
            nx = 1'b0; na = 8'h00; nb = 8'h00; nc = 3'd0;
        end else begin
            if (clr) begin
                nx = 1'b0; na = 8'h00;
            end else if (ldxa) begin
                nx = r9[8]; na = r9[7:0];
            end else if (sh) begin
                na = {mx, ma[7:1]};
            end
            if (ldb) nb = s;
            else if (sh) nb = {ma[0], mb[7:1]};
            if (clr) nc = 3'd0;
            else if (cnt) nc = (mc == 3'd7) ? 3'd0 : mc + 3'd1;
        end
        mx = nx; ma = na; mb = nb; mc = nc;
        exp_q.push_back({nx, na, nb, nc, nb[0]});
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        logic [20:0] e;
        drive(1, 0, 0, 0, 0, 0, 0, 8'h00);
        e = exp_q.pop_front(); checks++;
        if ({X, Aval, Bval, count, M} !== e) begin
            errors++; $display("FAIL reset_initial: got %h expected %h", {X, Aval, Bval, count, M}, e);
        end
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  8'($urandom));
            e = exp_q.pop_front(); checks++;
            if ({X, Aval, Bval, count, M} !== e) begin
                errors++; $display("FAIL random_prior: got %h expected %h", {X, Aval, Bval, count, M}, e);
            end
        end
        drive(1, 1'($urandom), 1, 1, 1, 1, 1'($urandom), 8'($urandom));
        e = exp_q.pop_front(); checks++;
        if ({X, Aval, Bval, count, M} !== 21'h0) begin
            errors++; $display("FAIL reset_dominates: got %h expected %h", {X, Aval, Bval, count, M}, 21'h0);
        end
    endtask

    task automatic test_clear_load();
        logic [20:0] e;
        drive(0, 0, 0, 0, 0, 1, 0, 8'h00);
        e = exp_q.pop_front(); checks++;
        if ({X, Aval, Bval, count, M} !== e) begin
            errors++; $display("FAIL pre_count: got %h expected %h", {X, Aval, Bval, count, M}, e);
        end
        drive(0, 1, 0, 1, 0, 0, 0, 8'h07);
        e = exp_q.pop_front(); checks++;
        if ({X, Aval, Bval, count, M} !== {1'b0, 8'h00, 8'h07, 3'd0, 1'b1}) begin
            errors++; $display("FAIL clear_load: got %h expected %h", {X, Aval, Bval, count, M},
                               {1'b0, 8'h00, 8'h07, 3'd0, 1'b1});
        end
    endtask

    task automatic test_addsub();
        logic [20:0] e;
        drive(0, 0, 1, 0, 0, 0, 0, 8'hC5);
        e = exp_q.pop_front(); checks++;
        if ({X, Aval} !== 9'h1C5 || {X, Aval, Bval, count, M} !== e) begin
            errors++; $display("FAIL add_c5: got %h expected %h", {X, Aval, Bval, count, M}, e);
        end
        drive(0, 0, 1, 0, 0, 0, 1, 8'hC5);
        e = exp_q.pop_front(); checks++;
        if ({X, Aval} !== 9'h000 || {X, Aval, Bval, count, M} !== e) begin
            errors++; $display("FAIL sub_c5: got %h expected %h", {X, Aval, Bval, count, M}, e);
        end
        // Extremes: -128 - 127 and 127 + 127 still fit the 9-bit sum.
        drive(0, 0, 1, 0, 0, 0, 0, 8'h80);
        e = exp_q.pop_front();
        drive(0, 0, 1, 0, 0, 0, 1, 8'h7F);
        e = exp_q.pop_front(); checks++;
        if ({X, Aval} !== 9'h101 || {X, Aval, Bval, count, M} !== e) begin
            errors++; $display("FAIL sub_extreme: got %h expected %h", {X, Aval, Bval, count, M}, e);
        end
    endtask

    task automatic test_shift();
        logic [20:0] e;
        drive(0, 1, 0, 1, 0, 0, 0, 8'h02);
        e = exp_q.pop_front();
        drive(0, 0, 1, 0, 0, 0, 0, 8'h81);
        e = exp_q.pop_front(); checks++;
        if ({X, Aval, Bval} !== {1'b1, 8'h81, 8'h02}) begin
            errors++; $display("FAIL shift_setup: got %h expected %h", {X, Aval, Bval}, {1'b1, 8'h81, 8'h02});
        end
        drive(0, 0, 0, 0, 1, 0, 0, 8'h00);
        e = exp_q.pop_front(); checks++;
        if ({X, Aval, Bval, M} !== {1'b1, 8'hC0, 8'h81, 1'b1} || {X, Aval, Bval, count, M} !== e) begin
            errors++; $display("FAIL shift_arith: got %h expected %h", {X, Aval, Bval, M},
                               {1'b1, 8'hC0, 8'h81, 1'b1});
        end
        drive(0, 0, 1, 0, 1, 0, 0, 8'h01);
        e = exp_q.pop_front(); checks++;
        if ({X, Aval, Bval} !== {1'b1, 8'hC1, 8'h40} || {X, Aval, Bval, count, M} !== e) begin
            errors++; $display("FAIL ldxa_with_shift: got %h expected %h", {X, Aval, Bval},
                               {1'b1, 8'hC1, 8'h40});
        end
    endtask

    task automatic run_multiply(input logic [7:0] multiplicand, input logic [7:0] multiplier,
                                input logic [15:0] product, input string name);
        logic [20:0] e;
        drive(0, 1, 0, 1, 0, 0, 0, multiplier);
        e = exp_q.pop_front(); checks++;
        if ({X, Aval, Bval, count, M} !== e) begin
            errors++; $display("FAIL %s_load: got %h expected %h", name, {X, Aval, Bval, count, M}, e);
        end
        for (int i = 0; i < 8; i++) begin
            if (mb[0]) begin
                drive(0, 0, 1, 0, 0, 0, (i == 7), multiplicand);
                e = exp_q.pop_front(); checks++;
                if ({X, Aval, Bval, count, M} !== e) begin
                    errors++; $display("FAIL %s_add%0d: got %h expected %h", name, i,
                                       {X, Aval, Bval, count, M}, e);
                end
            end
            drive(0, 0, 0, 0, 1, 1, 0, multiplicand);
            e = exp_q.pop_front(); checks++;
            if ({X, Aval, Bval, count, M} !== e) begin
                errors++; $display("FAIL %s_shift%0d: got %h expected %h", name, i,
                                   {X, Aval, Bval, count, M}, e);
            end
        end
        checks++;
        if ({X, Aval, Bval, count} !== {product[15], product, 3'd0}) begin
            errors++; $display("FAIL %s_product: got %h expected %h", name, {X, Aval, Bval, count},
                               {product[15], product, 3'd0});
        end
    endtask

    task automatic test_multiply();
        run_multiply(8'hFD, 8'h07, 16'hFFEB, "mul_m3x7");
        run_multiply(8'h80, 8'h80, 16'h4000, "mul_m128sq");
    endtask

    task automatic test_count_reset();
        logic [20:0] e;
        drive(0, 1, 0, 0, 0, 0, 0, 8'h00);
        e = exp_q.pop_front();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 8'h00);
            e = exp_q.pop_front(); checks++;
            if (count !== 3'((i + 1) % 8) || {X, Aval, Bval, count, M} !== e) begin
                errors++; $display("FAIL count_step%0d: got %0d expected %0d", i, count, (i + 1) % 8);
            end
        end
        drive(0, 1, 0, 1, 0, 0, 0, 8'hA5);
        e = exp_q.pop_front();
        drive(0, 0, 1, 0, 0, 0, 0, 8'h3C);
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 1, 1, 0, 8'h00);
            e = exp_q.pop_front();
        end
        checks++;
        if (count !== 3'd5 || {X, Aval, Bval, count, M} !== e) begin
            errors++; $display("FAIL count_at5: got %h expected %h", {X, Aval, Bval, count, M}, e);
        end
        drive(1, 0, 0, 0, 1, 1, 0, 8'h00);
        e = exp_q.pop_front(); checks++;
        if ({X, Aval, Bval, count, M} !== 21'h0 || e !== 21'h0) begin
            errors++; $display("FAIL reset_mid_shift: got %h expected %h", {X, Aval, Bval, count, M}, 21'h0);
        end
    endtask

    task automatic test_back_to_back();
        logic [20:0] e;
        for (int i = 0; i < 60; i++) begin
            drive(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 5) == 0), 1'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  8'($urandom));
            e = exp_q.pop_front(); checks++;
            if ({X, Aval, Bval, count, M} !== e) begin
                errors++; $display("FAIL b2b_%0d: got %h expected %h", i, {X, Aval, Bval, count, M}, e);
            end
        end
    endtask

    initial begin
        Reset = 1'b1; S = 8'h00; LD_XA = 1'b0; LD_B = 1'b0; Shift_EN = 1'b0;
        Cnt_EN = 1'b0; Clr_XA = 1'b0; SUB_ADD = 1'b0;
        mx = 1'b0; ma = 8'h00; mb = 8'h00; mc = 3'd0;
        @(posedge Clk);
        #1;
        test_reset();
        test_clear_load();
        test_addsub();
        test_shift();
        test_multiply();
        test_count_reset();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
